// File: rtl/bar_word_packer_if.sv
// Handshake bundle for bar_word_packer: element stream in, packed word stream out.
// Ports: in_valid/in_ready/in_foo/in_last (element side); out_valid/out_ready/out_bar/out_bytes/out_last (word side).
interface bar_word_packer_if #(
    parameter int FOO_W = 8,
    parameter int BAR_W = 32
);
    localparam int N  = BAR_W / FOO_W;
    localparam int BW = $clog2(N + 1);

    logic             in_valid;
    logic             in_ready;
    logic [FOO_W-1:0] in_foo;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [BAR_W-1:0] out_bar;
    logic [BW-1:0]    out_bytes;
    logic             out_last;

    modport master (
        output in_valid, in_foo, in_last, out_ready,
        input  in_ready, out_valid, out_bar, out_bytes, out_last
    );

    modport slave (
        input  in_valid, in_foo, in_last, out_ready,
        output in_ready, out_valid, out_bar, out_bytes, out_last
    );
endinterface

// File: rtl/bar_word_packer.sv
// Packs FOO_W-bit elements LSB-first into BAR_W-bit words; in_last flushes a partial word.
// Ports: clk, rst (async, active-high), bus (slave side of bar_word_packer_if), word_cnt (words delivered).
module bar_word_packer #(
    parameter int FOO_W = 8,
    parameter int BAR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    bar_word_packer_if.slave      bus,
    output logic [15:0]           word_cnt
);
    localparam int N  = BAR_W / FOO_W;
    localparam int CW = $clog2(N);
    localparam int BW = $clog2(N + 1);

    if ((BAR_W % FOO_W) != 0 || N < 2) begin : g_bad_params
        $error("bar_word_packer: BAR_W must be a multiple of FOO_W with ratio >= 2");
    end

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [BAR_W-1:0] acc;
    logic [CW-1:0]    acc_cnt;
    logic [BAR_W-1:0] merged;
    logic [BAR_W-1:0] bar_q;
    logic [BW-1:0]    bytes_q;
    logic             last_q;
    logic             completes;
    logic             in_fire;
    logic             out_fire;

    assign completes = bus.in_last || (acc_cnt == CW'(N - 1));

    // Only a word-completing element needs the output register, so
    // non-completing elements keep flowing into the accumulator while stalled.
    assign bus.in_ready = !(state == FULL && !bus.out_ready &&
                            bus.in_valid && completes);

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = (state == FULL) && bus.out_ready;

    // Slots above acc_cnt are always zero in acc, which zero-fills partial words.
    always_comb begin
        merged = acc;
        merged[acc_cnt*FOO_W +: FOO_W] = bus.in_foo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            acc      <= '0;
            acc_cnt  <= '0;
            bar_q    <= '0;
            bytes_q  <= '0;
            last_q   <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (out_fire) begin
                word_cnt <= word_cnt + 16'd1;
                state    <= EMPTY;
            end
            if (in_fire) begin
                if (completes) begin
                    bar_q   <= merged;
                    bytes_q <= BW'(acc_cnt) + BW'(1);
                    last_q  <= bus.in_last;
                    state   <= FULL;
                    acc     <= '0;
                    acc_cnt <= '0;
                end else begin
                    acc     <= merged;
                    acc_cnt <= acc_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_bar   = bar_q;
    assign bus.out_bytes = bytes_q;
    assign bus.out_last  = last_q;
endmodule

// File: doc/bar_word_packer.md
BAR_WORD_PACKER -- requirements
Module: bar_word_packer

Interface
REQ-001 Parameter: FOO_W, default 8, width of one input element in bits.
REQ-002 Parameter: BAR_W, default 32, width of one packed output word; SHALL be an integer multiple of FOO_W (N = BAR_W/FOO_W, N >= 2); elaboration SHALL fail otherwise.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  in_foo/in_last valid this cycle.
REQ-006 in_ready  output  1  block accepts the input element this cycle.
REQ-007 in_foo  input  FOO_W  input element.
REQ-008 in_last  input  1  element ends a packet; flushes a partial word.
REQ-009 out_valid  output  1  out_bar/out_bytes valid.
REQ-010 out_ready  input  1  downstream accepts the word this cycle.
REQ-011 out_bar  output  BAR_W  packed word; drives the_struct.bar of the sink-side bar interface.
REQ-012 out_bytes  output  clog2(N+1)  number of valid elements in out_bar (1..N).
REQ-013 out_last  output  1  word holds the packet's final element.
REQ-014 word_cnt  output  16  count of words delivered since reset; wraps 0xFFFF->0x0000.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-016 Elements SHALL pack LSB-first: element k of a word occupies out_bar[k*FOO_W +: FOO_W]; no width truncation or sign extension.
REQ-017 Accumulator SHALL hold 0..N-1 elements plus a fill count acc_cnt; an element completes a word when acc_cnt == N-1 or in_last == 1.
REQ-018 Output stage SHALL be one register with two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-019 in_ready SHALL be 1 unless the output stage is FULL and out_ready is 0 and the presented element would complete a word (in_ready may depend combinationally on out_ready, in_valid, in_last).
REQ-020 A non-completing accepted element SHALL be written to the accumulator at slot acc_cnt; acc_cnt increments.
REQ-021 A completing accepted element SHALL move accumulator plus element into the output register in the same edge: state->FULL, out_bytes = acc_cnt+1, out_last = in_last, acc_cnt->0.
REQ-022 Unused upper element slots of a partial word SHALL be zero in out_bar.
REQ-023 Latency: the completing element's edge SHALL assert out_valid the following cycle (1 cycle).
REQ-024 Simultaneous output transfer and completing input SHALL reload the output register; out_valid stays 1 (back-to-back, no bubble).
REQ-025 Output transfer with no completing input SHALL set state->EMPTY.
REQ-026 While FULL and not transferred, out_bar, out_bytes, out_last SHALL remain stable.
REQ-027 word_cnt SHALL increment by 1 on every output transfer.
REQ-028 in_last with acc_cnt == N-1 SHALL produce a full word with out_bytes = N and out_last = 1.
REQ-029 Sustained throughput with out_ready held 1 SHALL be one element per cycle.

Reset
REQ-030 rst high SHALL immediately force: out_valid=0, out_bar=0, out_bytes=0, out_last=0, word_cnt=0, acc_cnt=0, accumulator=0, state EMPTY.
REQ-031 Reset mid-word or mid-stall SHALL discard buffered elements; no partial word is emitted after reset release.
REQ-032 in_ready SHALL be 1 during and after reset (state EMPTY).

Verification
REQ-033 Defaults, out_ready=1; feed 0x05,0x00,0x00,0x00 -> one word out_bar=0x00000005, out_bytes=4, out_last=0, word_cnt=1, one cycle after 4th element.
REQ-034 Feed 0x11,0x22,0x33 with in_last on 0x33 -> out_bar=0x00332211, out_bytes=3, out_last=1.
REQ-035 out_ready=0; feed 8 elements 0x01..0x08 -> first word 0x04030201 held stable, 0x05-0x07 accepted, in_ready=0 on 0x08; release out_ready -> 0x04030201 then 0x08070605, no bubble, word_cnt=2.
REQ-036 Continuous stream of 4*K elements, out_ready=1 -> in_ready never 0, words emitted every 4 cycles, byte order preserved (scoreboard).
REQ-037 Assert rst after 2 elements and during a FULL stall -> all outputs zero immediately; next 4 elements 0xAA,0xBB,0xCC,0xDD yield exactly 0xDDCCBBAA.
REQ-038 Preload word_cnt to 0xFFFF via 65535 transfers, one more -> word_cnt=0x0000.
